// File: rtl/dcc_pkg.sv
// -----------------------------------------------------------------------------
// dcc_pkg
// Shared types, constants and helpers for the DCC frame serializer.
//   dcc_state_e      : serializer FSM states.
//   IDLE_ADDR/CMD    : idle packet content, sent when no user frame is pending.
//   FRAME_FIXED_BITS : frame bits beyond the preamble (3 bytes, 3 separators, stop).
//   dcc_half_cycles  : half-bit duration in clock cycles (64-bit arithmetic).
//   dcc_checksum     : DCC error-detection byte (XOR of address and command).
// -----------------------------------------------------------------------------
package dcc_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    LOAD = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } dcc_state_e;

  localparam logic [7:0] IDLE_ADDR = 8'hFF;
  localparam logic [7:0] IDLE_CMD  = 8'h00;

  localparam int unsigned FRAME_FIXED_BITS = 28;

  function automatic longint unsigned dcc_half_cycles(input longint unsigned clk_hz,
                                                      input longint unsigned us);
    return (clk_hz / 64'd1_000_000) * us;
  endfunction

  function automatic logic [7:0] dcc_checksum(input logic [7:0] addr,
                                              input logic [7:0] cmd);
    return addr ^ cmd;
  endfunction

endpackage

// File: rtl/dcc_bit_timer.sv
// -----------------------------------------------------------------------------
// dcc_bit_timer
// Times one DCC half-bit. A start pulse latches the bit value and restarts the
// count; done pulses on the last cycle of the half-bit (H1 cycles for a '1',
// H0 cycles for a '0'), after which the timer idles until the next start.
// Ports:
//   CLK    in  system clock
//   RESET  in  asynchronous active-high reset
//   start  in  begin a new half-bit on the next cycle
//   is_one in  bit value of the half-bit being started
//   done   out 1-cycle pulse in the final cycle of the half-bit
// -----------------------------------------------------------------------------
module dcc_bit_timer #(
  parameter int unsigned H1_CYC = 58,
  parameter int unsigned H0_CYC = 100
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  input  logic is_one,
  output logic done
);

  localparam int unsigned CW = (H0_CYC > 1) ? $clog2(H0_CYC) : 1;
  localparam logic [CW-1:0] LAST1 = CW'(H1_CYC - 1);
  localparam logic [CW-1:0] LAST0 = CW'(H0_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          is_one_q, is_one_d;
  logic [CW-1:0] last_cnt;

  // Terminal count for the bit being timed and the expiry pulse.
  always_comb begin
    last_cnt = is_one_q ? LAST1 : LAST0;
    done     = run_q && (cnt_q == last_cnt);
  end

  // Next-state: restart on start, stop at expiry, otherwise count while running.
  always_comb begin
    cnt_d    = cnt_q;
    run_d    = run_q;
    is_one_d = is_one_q;
    if (start) begin
      cnt_d    = {CW{1'b0}};
      run_d    = 1'b1;
      is_one_d = is_one;
    end else if (done) begin
      cnt_d = {CW{1'b0}};
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q    <= {CW{1'b0}};
      run_q    <= 1'b0;
      is_one_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      is_one_q <= is_one_d;
    end
  end

endmodule

// File: rtl/dcc_frame_serializer.sv
// -----------------------------------------------------------------------------
// dcc_frame_serializer
// Turns {address, command} byte pairs into a continuous NMRA DCC bitstream.
// Each frame is preamble, start bit, address, separator, command, separator,
// XOR checksum and stop bit, sent MSB first. When no frame is offered in LOAD
// an idle packet is sent so the track always carries signal.
// Ports:
//   CLK, RESET     clock, asynchronous active-high reset
//   enable         track output enable, sampled in OFF and at frame end
//   frame_valid    upstream frame offered (held until accepted)
//   frame_addr/cmd address and command bytes, captured in LOAD
//   frame_ready    high in LOAD; transfer on frame_valid & frame_ready
//   dcc_out        track polarity A
//   dcc_out_n      track polarity B (~dcc_out while transmitting, 0 in OFF)
//   busy           high in every state except OFF
//   frame_done     pulse in the last cycle of each stop bit
//   frame_is_idle  qualifies frame_done: finished frame was an idle packet
// -----------------------------------------------------------------------------
module dcc_frame_serializer
  import dcc_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
  parameter int unsigned T_ONE_US      = 58,
  parameter int unsigned T_ZERO_US     = 100,
  parameter int unsigned PREAMBLE_BITS = 14
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       enable,
  input  logic       frame_valid,
  input  logic [7:0] frame_addr,
  input  logic [7:0] frame_cmd,
  output logic       frame_ready,
  output logic       dcc_out,
  output logic       dcc_out_n,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_is_idle
);

  localparam longint unsigned H1_L = dcc_half_cycles(64'(CLK_FREQ_HZ), 64'(T_ONE_US));
  localparam longint unsigned H0_L = dcc_half_cycles(64'(CLK_FREQ_HZ), 64'(T_ZERO_US));
  localparam int unsigned H1 = 32'(H1_L);
  localparam int unsigned H0 = 32'(H0_L);

  localparam int unsigned FRAME_LEN = PREAMBLE_BITS + FRAME_FIXED_BITS;
  localparam int unsigned BCW       = $clog2(FRAME_LEN);
  localparam logic [BCW-1:0] LAST_BIT_IDX = BCW'(FRAME_LEN - 1);

  dcc_state_e           state_q, state_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 frame_is_idle_q, frame_is_idle_d;
  logic                 dcc_out_q, dcc_out_n_q, busy_q, frame_ready_q;

  logic                 tmr_start;
  logic                 tmr_done;
  logic                 frame_done_s;
  logic [FRAME_LEN-1:0] user_frame;
  logic [FRAME_LEN-1:0] idle_frame;

  // Fully framed user and idle packets, ready to load into the shift register.
  always_comb begin
    user_frame = {{PREAMBLE_BITS{1'b1}}, 1'b0, frame_addr, 1'b0, frame_cmd, 1'b0,
                  dcc_checksum(frame_addr, frame_cmd), 1'b1};
    idle_frame = {{PREAMBLE_BITS{1'b1}}, 1'b0, IDLE_ADDR, 1'b0, IDLE_CMD, 1'b0,
                  dcc_checksum(IDLE_ADDR, IDLE_CMD), 1'b1};
  end

  // FSM next-state, shift/count updates and half-bit timer restarts.
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    frame_is_idle_d = frame_is_idle_q;
    tmr_start       = 1'b0;
    frame_done_s    = 1'b0;
    case (state_q)
      OFF: begin
        if (enable) begin
          state_d = LOAD;
        end else begin
          state_d = OFF;
        end
      end
      LOAD: begin
        if (frame_valid) begin
          shift_d         = user_frame;
          frame_is_idle_d = 1'b0;
        end else begin
          shift_d         = idle_frame;
          frame_is_idle_d = 1'b1;
        end
        bit_cnt_d = LAST_BIT_IDX;
        tmr_start = 1'b1;
        state_d   = HIGH;
      end
      HIGH: begin
        if (tmr_done) begin
          tmr_start = 1'b1;
          state_d   = LOW;
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (tmr_done) begin
          if (bit_cnt_q != {BCW{1'b0}}) begin
            shift_d   = {shift_q[FRAME_LEN-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BCW'(1);
            tmr_start = 1'b1;
            state_d   = HIGH;
          end else begin
            // Stop bit finished; enable is only looked at here mid-stream.
            frame_done_s = 1'b1;
            if (enable) begin
              state_d = LOAD;
            end else begin
              state_d = OFF;
            end
          end
        end else begin
          state_d = LOW;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  // shift_d MSB is the bit whose half-bit starts next, whether freshly loaded,
  // just shifted, or unchanged for the LOW half.
  dcc_bit_timer #(
    .H1_CYC(H1),
    .H0_CYC(H0)
  ) u_bit_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .start (tmr_start),
    .is_one(shift_d[FRAME_LEN-1]),
    .done  (tmr_done)
  );

  // FSM, frame data and bit counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q         <= OFF;
      shift_q         <= {FRAME_LEN{1'b0}};
      bit_cnt_q       <= {BCW{1'b0}};
      frame_is_idle_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      frame_is_idle_q <= frame_is_idle_d;
    end
  end

  // Output flops decoded from the next state. LOAD drives the track high so
  // it simply stretches the first preamble half-bit by one cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dcc_out_q     <= 1'b0;
      dcc_out_n_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      dcc_out_q     <= (state_d == LOAD) || (state_d == HIGH);
      dcc_out_n_q   <= (state_d == LOW);
      busy_q        <= (state_d != OFF);
      frame_ready_q <= (state_d == LOAD);
    end
  end

  assign dcc_out       = dcc_out_q;
  assign dcc_out_n     = dcc_out_n_q;
  assign busy          = busy_q;
  assign frame_ready   = frame_ready_q;
  assign frame_is_idle = frame_is_idle_q;
  assign frame_done    = frame_done_s;

endmodule

// File: tb/tb_dcc_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_dcc_frame_serializer
// Directed bench for dcc_frame_serializer at 1 MHz (H1=58, H0=100 cycles).
// A negedge monitor decodes the track waveform back into frame bits and
// checks every half-bit length; the main sequence compares decoded frames,
// handshake and state outputs against hand-written expected values.
// -----------------------------------------------------------------------------
module tb_dcc_frame_serializer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       enable = 1'b0;
  logic       frame_valid = 1'b0;
  logic [7:0] frame_addr = 8'h00;
  logic [7:0] frame_cmd = 8'h00;
  logic       frame_ready, dcc_out, dcc_out_n, busy, frame_done, frame_is_idle;

  always #5 CLK = ~CLK;

  dcc_frame_serializer #(
    .CLK_FREQ_HZ  (1_000_000),
    .T_ONE_US     (58),
    .T_ZERO_US    (100),
    .PREAMBLE_BITS(14)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .enable       (enable),
    .frame_valid  (frame_valid),
    .frame_addr   (frame_addr),
    .frame_cmd    (frame_cmd),
    .frame_ready  (frame_ready),
    .dcc_out      (dcc_out),
    .dcc_out_n    (dcc_out_n),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_is_idle(frame_is_idle)
  );

  // Hand-assembled frames; checksums 03^3F=3C, 05^74=71, FF^00=FF.
  localparam logic [41:0] IDLE_F = {14'h3FFF, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1};
  localparam logic [41:0] USR1_F = {14'h3FFF, 1'b0, 8'h03, 1'b0, 8'h3F, 1'b0, 8'h3C, 1'b1};
  localparam logic [41:0] USR2_F = {14'h3FFF, 1'b0, 8'h05, 1'b0, 8'h74, 1'b0, 8'h71, 1'b1};

  int n_chk = 0;
  int n_bad = 0;

  int          cyc = 0;
  int          hi_run = 0;
  int          lo_run = 0;
  int          nbits = 0;
  int          half_err = 0;
  int          pol_err = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_nbits = 0;
  logic [41:0] frame_bits = 42'h0;
  logic [41:0] last_bits = 42'h0;
  logic        last_idle = 1'b0;

  int c0, t0, k;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic finish_bit();
    if ((hi_run != lo_run) || ((lo_run != 58) && (lo_run != 100))) half_err++;
    frame_bits = {frame_bits[40:0], (lo_run == 58) ? 1'b1 : 1'b0};
    nbits++;
    hi_run = 0;
    lo_run = 0;
  endtask

  // Waveform monitor: decodes bits, checks half-bit lengths and polarity.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (dcc_out_n !== (busy ? ~dcc_out : 1'b0)) pol_err++;
      if (frame_ready && !dcc_out) pol_err++;
      if (RESET || !busy || frame_ready) begin
        hi_run = 0;
        lo_run = 0;
        nbits = 0;
        frame_bits = 42'h0;
      end else if (dcc_out) begin
        if (lo_run > 0) finish_bit();
        hi_run++;
      end else begin
        lo_run++;
        if (frame_done) finish_bit();
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        last_bits = frame_bits;
        last_nbits = nbits;
        last_idle = frame_is_idle;
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = done_cnt;
    int n = 0;
    while (done_cnt == c && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_done_seen"}, (done_cnt != c), 1'b1);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!frame_ready && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_ready_seen"}, frame_ready, 1'b1);
  endtask

  initial begin
    #(95_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with enable held high
    RESET = 1'b1;
    enable = 1'b1;
    frame_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("rst_outs", {dcc_out, dcc_out_n, busy, frame_ready, frame_done, frame_is_idle}, 6'b0);
    end
    RESET = 1'b0;
    step();
    check_eq("load_after_rst", {frame_ready, busy, dcc_out, dcc_out_n}, 4'b1110);

    // 2. idle packets and frame period
    wait_done("idle1", 7000);
    check_eq("idle1_flag", last_idle, 1'b1);
    check_eq("idle1_bits", last_bits, IDLE_F);
    check_eq("idle1_nbits", last_nbits, 42);
    t0 = done_cyc;
    wait_done("idle2", 7000);
    check_eq("idle_period", done_cyc - t0, 5797);
    check_eq("idle2_bits", last_bits, IDLE_F);

    // 3. single user frame, upstream data changed after capture
    frame_valid = 1'b1;
    frame_addr = 8'h03;
    frame_cmd = 8'h3F;
    wait_ready("usr1", 10);
    step();
    check_eq("ready_width", frame_ready, 1'b0);
    frame_valid = 1'b0;
    frame_addr = 8'hAA;
    frame_cmd = 8'h55;
    wait_done("usr1", 7000);
    check_eq("usr1_flag", last_idle, 1'b0);
    check_eq("usr1_bits", last_bits, USR1_F);
    check_eq("usr1_nbits", last_nbits, 42);

    // 4. back-to-back user frames
    frame_valid = 1'b1;
    frame_addr = 8'h03;
    frame_cmd = 8'h3F;
    wait_ready("b2b_a", 10);
    step();
    frame_addr = 8'h05;
    frame_cmd = 8'h74;
    c0 = done_cnt;
    wait_done("b2b_a", 7000);
    check_eq("b2b_a_bits", last_bits, USR1_F);
    check_eq("b2b_a_flag", last_idle, 1'b0);
    wait_ready("b2b_b", 10);
    step();
    frame_valid = 1'b0;
    wait_done("b2b_b", 7000);
    check_eq("b2b_b_bits", last_bits, USR2_F);
    check_eq("b2b_b_flag", last_idle, 1'b0);
    check_eq("b2b_no_idle", done_cnt - c0, 2);
    check_eq("half_len_b2b", half_err, 0);

    // 5. disable at bit 20
    wait_ready("dis", 10);
    k = 0;
    while (nbits < 20 && k < 6000) begin
      step();
      k++;
    end
    check_eq("dis_bit20", nbits, 20);
    enable = 1'b0;
    wait_done("dis", 7000);
    check_eq("dis_flag", last_idle, 1'b1);
    check_eq("dis_bits", last_bits, IDLE_F);
    step();
    check_eq("dis_off", {dcc_out, dcc_out_n, busy, frame_ready}, 4'b0);
    c0 = done_cnt;
    repeat (20) step();
    check_eq("dis_stays_off", {busy, dcc_out, dcc_out_n}, 3'b0);
    check_eq("dis_no_done", done_cnt - c0, 0);

    // 6. reset inside a HIGH half-bit
    enable = 1'b1;
    wait_ready("rst", 10);
    k = 0;
    while (!(nbits >= 3 && dcc_out && !frame_ready) && k < 3000) begin
      step();
      k++;
    end
    check_eq("rst_in_high", dcc_out, 1'b1);
    c0 = done_cnt;
    RESET = 1'b1;
    #1;
    check_eq("rst_async", {dcc_out, dcc_out_n, busy, frame_ready, frame_done, frame_is_idle}, 6'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_hold_done", frame_done, 1'b0);
    end
    RESET = 1'b0;
    step();
    check_eq("rst_reload", frame_ready, 1'b1);
    wait_done("rst_fresh", 7000);
    check_eq("rst_fresh_bits", last_bits, IDLE_F);
    check_eq("rst_fresh_nbits", last_nbits, 42);
    check_eq("rst_fresh_flag", last_idle, 1'b1);
    check_eq("rst_one_done", done_cnt - c0, 1);

    check_eq("half_len_all", half_err, 0);
    check_eq("polarity", pol_err, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
